// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS core encodings: ALU control, HI/LO op codes, sequencer states
package mips_pkg;

   localparam logic [3:0] ALUC_ADDU = 4'b0000;
   localparam logic [3:0] ALUC_SUBU = 4'b0001;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [2:0] {
      MDS_IDLE,
      MDS_P1,
      MDS_P2,
      MDS_IT,
      MDS_Q1,
      MDS_Q2,
      MDS_DONE
   } mds_state_e;

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - HI/LO unit request/result bus plus its view of the shared ALU
interface muldiv_seq_if;

   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_aluc;
   logic [31:0] alu_r;
   logic        alu_carry;

   modport slave (
      input  start, op, a, b, flush, wr_hi, wr_lo, wr_data, alu_r, alu_carry,
      output busy, done, hi, lo, alu_a, alu_b, alu_aluc
   );

   modport master (
      output start, op, a, b, flush, wr_hi, wr_lo, wr_data, alu_r, alu_carry,
      input  busy, done, hi, lo, alu_a, alu_b, alu_aluc
   );

endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - fixed-latency MULT/MULTU/DIV/DIVU sequencer on the shared ADDU/SUBU ALU
module muldiv_seq
   import mips_pkg::*;
#(
   parameter int              DW      = 32,
   parameter logic [DW-1:0]   DIV0_LO = 32'hFFFFFFFF
) (
   input  logic           clk,
   input  logic           rst_n,
   muldiv_seq_if.slave    bus
);

   mds_state_e    state;
   logic [4:0]    cnt;
   logic          is_div, sgn, s_q, s_r, div0, lz;
   logic          busy_r, done_r;
   logic [DW-1:0] opa, opb, pa, pb;
   logic [DW-1:0] acc, mq, lo_w;
   logic [DW-1:0] hi_r, lo_r;
   logic [DW-1:0] alu_a, alu_b;
   logic [3:0]    aluc;
   logic [DW-1:0] t;
   logic          take;

   // Divide reuses acc as remainder and mq as quotient.
   assign t    = {acc[DW-2:0], mq[DW-1]};
   assign take = acc[DW-1] | ~bus.alu_carry;

   always_comb begin
      alu_a = '0;
      alu_b = '0;
      aluc  = ALUC_ADDU;
      case (state)
         MDS_P1: begin
            aluc  = ALUC_SUBU;
            alu_b = opa;
         end
         MDS_P2: begin
            aluc  = ALUC_SUBU;
            alu_b = opb;
         end
         MDS_IT: begin
            if (is_div) begin
               aluc  = ALUC_SUBU;
               alu_a = t;
               alu_b = pb;
            end else begin
               alu_a = acc;
               alu_b = pa;
            end
         end
         MDS_Q1: begin
            if (s_q && !div0) begin
               aluc  = ALUC_SUBU;
               alu_b = mq;
            end
         end
         MDS_Q2: begin
            if (!is_div && s_q) begin
               alu_a = ~acc;
               alu_b = {{(DW-1){1'b0}}, lz};
            end else if (is_div && s_r && !div0) begin
               aluc  = ALUC_SUBU;
               alu_b = acc;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= MDS_IDLE;
         cnt    <= '0;
         is_div <= 1'b0;
         sgn    <= 1'b0;
         s_q    <= 1'b0;
         s_r    <= 1'b0;
         div0   <= 1'b0;
         lz     <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         opa    <= '0;
         opb    <= '0;
         pa     <= '0;
         pb     <= '0;
         acc    <= '0;
         mq     <= '0;
         lo_w   <= '0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else if (state != MDS_IDLE && bus.flush) begin
         state  <= MDS_IDLE;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            MDS_IDLE: begin
               if (bus.start) begin
                  state  <= MDS_P1;
                  busy_r <= 1'b1;
                  opa    <= bus.a;
                  opb    <= bus.b;
                  is_div <= op_is_div(bus.op);
                  sgn    <= op_is_signed(bus.op);
                  s_q    <= op_is_signed(bus.op) & (bus.a[DW-1] ^ bus.b[DW-1]);
                  s_r    <= op_is_signed(bus.op) & bus.a[DW-1];
                  div0   <= op_is_div(bus.op) && (bus.b == '0);
               end else begin
                  if (bus.wr_hi) hi_r <= bus.wr_data;
                  if (bus.wr_lo) lo_r <= bus.wr_data;
               end
            end
            MDS_P1: begin
               pa    <= (sgn && opa[DW-1]) ? bus.alu_r : opa;
               state <= MDS_P2;
            end
            MDS_P2: begin
               pb    <= (sgn && opb[DW-1]) ? bus.alu_r : opb;
               mq    <= is_div ? pa : ((sgn && opb[DW-1]) ? bus.alu_r : opb);
               acc   <= '0;
               cnt   <= '0;
               state <= MDS_IT;
            end
            MDS_IT: begin
               if (is_div) begin
                  acc <= take ? bus.alu_r : t;
                  mq  <= {mq[DW-2:0], take};
               end else if (mq[0]) begin
                  acc <= {bus.alu_carry, bus.alu_r[DW-1:1]};
                  mq  <= {bus.alu_r[0], mq[DW-1:1]};
               end else begin
                  acc <= {1'b0, acc[DW-1:1]};
                  mq  <= {acc[0], mq[DW-1:1]};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) state <= MDS_Q1;
            end
            MDS_Q1: begin
               lo_w  <= div0 ? DIV0_LO : (s_q ? bus.alu_r : mq);
               lz    <= (mq == '0);
               state <= MDS_Q2;
            end
            MDS_Q2: begin
               lo_r <= lo_w;
               if (div0)
                  hi_r <= opa;
               else if ((!is_div && s_q) || (is_div && s_r))
                  hi_r <= bus.alu_r;
               else
                  hi_r <= acc;
               done_r <= 1'b1;
               state  <= MDS_DONE;
            end
            MDS_DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= MDS_IDLE;
            end
            default: state <= MDS_IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.hi       = hi_r;
   assign bus.lo       = lo_r;
   assign bus.alu_a    = alu_a;
   assign bus.alu_b    = alu_b;
   assign bus.alu_aluc = aluc;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized and directed bench for muldiv_seq against an arithmetic model
module tb_muldiv_seq;
   import mips_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   aluc_bad;

   muldiv_seq_if bus();

   muldiv_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Parent-side ALU: ADDU carry-out, SUBU borrow.
   always_comb begin
      bus.alu_r     = '0;
      bus.alu_carry = 1'b0;
      case (bus.alu_aluc)
         ALUC_ADDU: {bus.alu_carry, bus.alu_r} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
         ALUC_SUBU: begin
            bus.alu_r     = bus.alu_a - bus.alu_b;
            bus.alu_carry = (bus.alu_a < bus.alu_b);
         end
         default: ;
      endcase
   end

   always @(negedge clk)
      if (rst_n && bus.alu_aluc !== ALUC_ADDU && bus.alu_aluc !== ALUC_SUBU) aluc_bad++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: p = sa * sb;
         2'b01: p = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 32'd0) p = {a, 32'hFFFFFFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) p = {a, 32'hFFFFFFFF};
            else p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Runs one operation from accept (C0) through C38 and checks timing and result.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit wr_at_accept, input bit start_again,
                         input bit wr_busy);
      logic [63:0] exp;
      logic [31:0] pre_hi, pre_lo, got_hi, got_lo;
      int done_cnt, done_at;
      bit busy_ok, hold_ok;
      exp = ref_model(op, a, b);
      pre_hi = bus.hi;
      pre_lo = bus.lo;
      done_cnt = 0;
      done_at = -1;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      got_hi = '0;
      got_lo = '0;
      bus.start = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      if (wr_at_accept) begin
         bus.wr_lo = 1'b1;
         bus.wr_data = 32'h12345678;
      end
      for (int c = 1; c <= 37; c++) begin
         step();
         if (c == 1) begin
            bus.start = 1'b0;
            bus.wr_lo = 1'b0;
            bus.op = 2'($urandom_range(0, 3));
            bus.a = $urandom;
            bus.b = $urandom;
         end
         if (!bus.busy) busy_ok = 1'b0;
         if (bus.done) begin
            done_cnt++;
            done_at = c;
         end
         if (c < 37 && (bus.hi !== pre_hi || bus.lo !== pre_lo)) hold_ok = 1'b0;
         if (c == 37) begin
            got_hi = bus.hi;
            got_lo = bus.lo;
         end
         bus.start = (start_again && c == 5);
         if (wr_busy && c == 3) begin
            bus.wr_hi = 1'b1;
            bus.wr_data = 32'h0BADF00D;
         end
         if (c == 10) bus.wr_hi = 1'b0;
      end
      bus.start = 1'b0;
      step();
      check({tag, ".busy_window"}, 64'(busy_ok), 64'd1);
      check({tag, ".done_cycle"}, 64'(done_at), 64'd37);
      check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
      check({tag, ".hold"}, 64'(hold_ok), 64'd1);
      check({tag, ".hi"}, 64'(got_hi), 64'(exp[63:32]));
      check({tag, ".lo"}, 64'(got_lo), 64'(exp[31:0]));
      check({tag, ".busy_after"}, 64'(bus.busy), 64'd0);
      check({tag, ".done_after"}, 64'(bus.done), 64'd0);
   endtask

   task automatic set_hilo(input logic [31:0] v);
      bus.wr_hi = 1'b1;
      bus.wr_lo = 1'b1;
      bus.wr_data = v;
      step();
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
   endtask

   initial begin
      int done_seen;
      logic [1:0] rop;
      logic [31:0] ra, rb;
      n_tests = 0;
      n_fail = 0;
      aluc_bad = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.a = '0;
      bus.b = '0;
      bus.flush = 1'b0;
      bus.wr_hi = 1'b0;
      bus.wr_lo = 1'b0;
      bus.wr_data = '0;
      #1;
      check("reset.busy", 64'(bus.busy), 64'd0);
      check("reset.done", 64'(bus.done), 64'd0);
      check("reset.hilo", {bus.hi, bus.lo}, 64'd0);
      check("reset.alu", {bus.alu_a, bus.alu_b}, 64'd0);
      check("reset.aluc", 64'(bus.alu_aluc), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
      check("multu_max.lit", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
      run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'h00000005, 0, 0, 0);
      check("mult_neg.lit", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFF1);
      run_op("mult_lz", 2'b00, 32'h80000000, 32'h00000002, 0, 0, 0);
      check("mult_lz.lit", {bus.hi, bus.lo}, 64'hFFFFFFFF_00000000);
      run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h00000002, 0, 0, 0);
      check("div_neg.lit", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFD);
      run_op("divu_msb", 2'b11, 32'hFFFFFFFF, 32'h80000001, 0, 0, 0);
      check("divu_msb.lit", {bus.hi, bus.lo}, 64'h7FFFFFFE_00000001);
      run_op("divu_zero", 2'b11, 32'h00001234, 32'h0, 0, 0, 0);
      check("divu_zero.lit", {bus.hi, bus.lo}, 64'h00001234_FFFFFFFF);
      run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);

      set_hilo(32'hAAAA5555);
      check("preset.hilo", {bus.hi, bus.lo}, 64'hAAAA5555_AAAA5555);
      run_op("restart", 2'b01, 32'h00010001, 32'h0000FFFF, 0, 1, 0);

      // Flush in C10.
      set_hilo(32'hAAAA5555);
      bus.start = 1'b1;
      bus.op = 2'b01;
      bus.a = 32'h11111111;
      bus.b = 32'h22222222;
      done_seen = 0;
      for (int c = 1; c <= 11; c++) begin
         step();
         bus.start = 1'b0;
         if (bus.done) done_seen++;
         bus.flush = (c == 10);
      end
      check("flush.busy", 64'(bus.busy), 64'd0);
      bus.flush = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (bus.done || bus.busy) done_seen++;
      end
      check("flush.no_done", 64'(done_seen), 64'd0);
      check("flush.hilo", {bus.hi, bus.lo}, 64'hAAAA5555_AAAA5555);

      // Async reset in C20.
      bus.start = 1'b1;
      bus.op = 2'b10;
      bus.a = 32'h7FFFFFFF;
      bus.b = 32'h00000003;
      for (int c = 1; c <= 20; c++) begin
         step();
         bus.start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("arst.busy", 64'(bus.busy), 64'd0);
      check("arst.hilo", {bus.hi, bus.lo}, 64'd0);
      check("arst.alu", {bus.alu_a, bus.alu_b, 28'd0, bus.alu_aluc}, 64'd0);
      step();
      rst_n = 1'b1;
      done_seen = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.done || bus.busy) done_seen++;
      end
      check("arst.quiet", 64'(done_seen), 64'd0);

      bus.wr_hi = 1'b1;
      bus.wr_data = 32'hDEADBEEF;
      step();
      bus.wr_hi = 1'b0;
      check("mthi", 64'(bus.hi), 64'hDEADBEEF);
      check("mthi.lo_kept", 64'(bus.lo), 64'd0);

      run_op("mtlo_accept", 2'b00, 32'h00000007, 32'hFFFFFFFE, 1, 0, 0);
      run_op("mthi_busy", 2'b11, 32'h89ABCDEF, 32'h00000013, 0, 0, 1);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: rb = -32'($urandom_range(1, 15));
            3: ra = {1'b1, 31'd0};
            default: ;
         endcase
         run_op($sformatf("rnd%0d", i), rop, ra, rb, 0, 0, 0);
      end

      check("aluc_legal", 64'(aluc_bad), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
